// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the mux select scanner.
//   DEF_SEL_W / DEF_N_CH : default select width and channel count
//   SETTLE_CNT_W         : width of the per-channel settle counter
//   ST_*                 : scanner FSM state codes
package mux_scan_pkg;

  localparam int unsigned DEF_SEL_W    = 4;
  localparam int unsigned DEF_N_CH     = 16;
  localparam int unsigned SETTLE_CNT_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/mux_sel_scanner_if.sv
// Control/data bundle between the scanner, its requester and the channel mux.
//   start, cont, stop : sweep request, continuous-mode flag, end-of-continuous request
//   sel, y_in         : mux select out, mux output back
//   data_out          : last completed sweep word
//   data_valid, busy  : update pulse, not-idle status
// master = scanner side, slave = requester/mux side.
interface mux_sel_scanner_if
  import mux_scan_pkg::*;
#(
  parameter int unsigned SEL_W = DEF_SEL_W,
  parameter int unsigned N_CH  = DEF_N_CH
);

  logic             start;
  logic             cont;
  logic             stop;
  logic [SEL_W-1:0] sel;
  logic             y_in;
  logic [N_CH-1:0]  data_out;
  logic             data_valid;
  logic             busy;

  modport master (
    input  start, cont, stop, y_in,
    output sel, data_out, data_valid, busy
  );

  modport slave (
    output start, cont, stop, y_in,
    input  sel, data_out, data_valid, busy
  );

endinterface

// File: rtl/mux_settle_timer.sv
// Loadable down-counter that paces the settle wait after each select change.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (has priority over dec)
//   dec       : decrement, saturating at zero
//   zero_c    : combinational flag, counter is zero
module mux_settle_timer
  import mux_scan_pkg::*;
#(
  parameter int unsigned CNT_W = SETTLE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] count_q;

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/mux_sel_scanner.sv
// Sweeps the mux select 0..N_CH-1, waits SETTLE cycles per channel, samples
// y_in and publishes the assembled word. Single-shot or continuous sweeps.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mux_sel_scanner_if.master (start/cont/stop/y_in in;
//              sel/data_out/data_valid/busy out, all registered)
module mux_sel_scanner
  import mux_scan_pkg::*;
#(
  parameter int unsigned SEL_W  = DEF_SEL_W,
  parameter int unsigned N_CH   = DEF_N_CH,
  parameter int unsigned SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  mux_sel_scanner_if.master   bus
);

  localparam logic [SEL_W-1:0]        LAST_SEL = SEL_W'(N_CH - 1);
  // Counter holds the remaining extra settle cycles after the first one
  localparam logic [SETTLE_CNT_W-1:0] LOAD_VAL =
    (SETTLE == 0) ? '0 : SETTLE_CNT_W'(SETTLE - 1);

  state_t           state_q, state_nxt;
  logic [SEL_W-1:0] sel_q, sel_nxt;
  logic [N_CH-1:0]  shadow_q, shadow_nxt;
  logic [N_CH-1:0]  data_out_q, data_out_nxt;
  logic             valid_q, valid_nxt;
  logic             busy_q, busy_nxt;
  logic             cont_q, cont_nxt;
  logic             stop_q, stop_nxt;
  logic             tmr_load, tmr_dec, tmr_zero_c;

  mux_settle_timer #(.CNT_W(SETTLE_CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (LOAD_VAL),
    .zero_c   (tmr_zero_c)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      shadow_q   <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      cont_q     <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      sel_q      <= sel_nxt;
      shadow_q   <= shadow_nxt;
      data_out_q <= data_out_nxt;
      valid_q    <= valid_nxt;
      busy_q     <= busy_nxt;
      cont_q     <= cont_nxt;
      stop_q     <= stop_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state_q;
    sel_nxt      = sel_q;
    shadow_nxt   = shadow_q;
    data_out_nxt = data_out_q;
    valid_nxt    = 1'b0;
    cont_nxt     = cont_q;
    // stop is only remembered while a sweep is running
    stop_nxt     = stop_q | (bus.stop && (state_q != ST_IDLE));
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sel_nxt  = '0;
        stop_nxt = 1'b0;
        if (bus.start) begin
          cont_nxt   = bus.cont;
          shadow_nxt = '0;
          if (SETTLE == 0) begin
            state_nxt = ST_SAMPLE;
          end else begin
            state_nxt = ST_SETTLE;
            tmr_load  = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        if (tmr_zero_c) begin
          state_nxt = ST_SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_SAMPLE: begin
        shadow_nxt[sel_q] = bus.y_in;
        // Increment wraps LAST_SEL back to 0 on the way into DONE
        sel_nxt = sel_q + SEL_W'(1);
        if (sel_q == LAST_SEL) begin
          state_nxt    = ST_DONE;
          data_out_nxt = shadow_nxt;
          valid_nxt    = 1'b1;
        end else if (SETTLE == 0) begin
          state_nxt = ST_SAMPLE;
        end else begin
          state_nxt = ST_SETTLE;
          tmr_load  = 1'b1;
        end
      end

      ST_DONE: begin
        if (cont_q && !(stop_q || bus.stop)) begin
          if (SETTLE == 0) begin
            state_nxt = ST_SAMPLE;
          end else begin
            state_nxt = ST_SETTLE;
            tmr_load  = 1'b1;
          end
        end else begin
          state_nxt = ST_IDLE;
          stop_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  assign bus.sel        = sel_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Self-checking bench for mux_sel_scanner: two instances (SETTLE=1 and 0), each
// fed by a behavioural 16:1 mux y = d[sel]. Expectations come from the timing
// rules: channel k is on sel during cycles k*(S+1)+1 .. (k+1)*(S+1), valid lands
// at cycle 16*(S+1)+1 and the word equals d.
module tb_mux_sel_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] d_a, d_b;
  logic        fast;
  int          checks = 0;
  int          errors = 0;

  mux_sel_scanner_if bus_a ();
  mux_sel_scanner_if bus_b ();

  assign bus_a.y_in = d_a[bus_a.sel];
  assign bus_b.y_in = d_b[bus_b.sel];

  mux_sel_scanner #(.SETTLE(1)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mux_sel_scanner #(.SETTLE(0)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic [3:0]  sel_o;
  logic [15:0] dout_o;
  logic        valid_o, busy_o;

  always_comb begin
    sel_o   = fast ? bus_b.sel        : bus_a.sel;
    dout_o  = fast ? bus_b.data_out   : bus_a.data_out;
    valid_o = fast ? bus_b.data_valid : bus_a.data_valid;
    busy_o  = fast ? bus_b.busy       : bus_a.busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic ct, input logic sp);
    if (fast) begin
      bus_b.start = st; bus_b.cont = ct; bus_b.stop = sp;
    end else begin
      bus_a.start = st; bus_a.cont = ct; bus_a.stop = sp;
    end
  endtask

  // One single-shot sweep; optional start pokes at cycles 5 and 20 while busy
  task automatic single_sweep(input bit f, input logic [15:0] word, input bit poke, input string tag);
    int   period;
    int   vcyc;
    int   vcount;
    int   vfirst;
    logic [15:0] wout;
    bit   sel_ok;
    bit   busy_ok;
    period  = f ? 1 : 2;
    vcyc    = 16 * period + 1;
    vcount  = 0;
    vfirst  = -1;
    wout    = '0;
    sel_ok  = 1'b1;
    busy_ok = 1'b1;
    fast    = f;
    if (f) d_b = word; else d_a = word;
    tick();
    chk({tag, "_idle_before"}, 32'(busy_o), 32'(0));
    drive(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= vcyc + 3; c++) begin
      tick();
      drive(poke && (c == 5 || c == 20), 1'b0, 1'b0);
      if (busy_o !== (c <= vcyc)) busy_ok = 1'b0;
      if (32'(sel_o) !== ((c < vcyc) ? 32'((c - 1) / period) : 32'(0))) sel_ok = 1'b0;
      if (valid_o === 1'b1) begin
        vcount++;
        if (vfirst < 0) begin
          vfirst = c;
          wout   = dout_o;
        end
      end
    end
    chk({tag, "_valid_count"}, 32'(vcount), 32'(1));
    chk({tag, "_valid_cycle"}, 32'(vfirst), 32'(vcyc));
    chk({tag, "_word"}, 32'(wout), 32'(word));
    chk({tag, "_sel_sequence"}, 32'(sel_ok), 32'(1));
    chk({tag, "_busy_window"}, 32'(busy_ok), 32'(1));
    chk({tag, "_word_held"}, 32'(dout_o), 32'(word));
    chk({tag, "_sel_home"}, 32'(sel_o), 32'(0));
  endtask

  initial begin : main
    int          vcount;
    int          vcyc_q[$];
    logic [15:0] word_q[$];
    logic [15:0] w;
    logic        busy_99, busy_100;

    rst  = 1'b1;
    fast = 1'b0;
    d_a  = '0;
    d_b  = '0;
    bus_a.start = 1'b0; bus_a.cont = 1'b0; bus_a.stop = 1'b0;
    bus_b.start = 1'b0; bus_b.cont = 1'b0; bus_b.stop = 1'b0;
    repeat (3) tick();

    // Reset values on both instances
    chk("rst_a_sel",   32'(bus_a.sel),        32'(0));
    chk("rst_a_dout",  32'(bus_a.data_out),   32'(0));
    chk("rst_a_valid", 32'(bus_a.data_valid), 32'(0));
    chk("rst_a_busy",  32'(bus_a.busy),       32'(0));
    chk("rst_b_sel",   32'(bus_b.sel),        32'(0));
    chk("rst_b_dout",  32'(bus_b.data_out),   32'(0));
    chk("rst_b_valid", 32'(bus_b.data_valid), 32'(0));
    chk("rst_b_busy",  32'(bus_b.busy),       32'(0));
    rst = 1'b0;
    tick();

    // Directed single sweep, then start pokes while busy
    single_sweep(1'b0, 16'hA5C3, 1'b0, "single_a5c3");
    single_sweep(1'b0, 16'h3C96, 1'b1, "busy_start");

    // Randomized single sweeps on both settle settings
    for (int i = 0; i < 4; i++) begin
      w = 16'($urandom);
      single_sweep(1'b0, w, 1'b0, "rand_s1");
      w = 16'($urandom);
      single_sweep(1'b1, w, 1'b0, "rand_s0");
    end
    single_sweep(1'b1, 16'hFFFF, 1'b0, "s0_all_ones");

    // Continuous mode; stop with start in IDLE is ignored, stop in sweep 3 ends it
    fast     = 1'b0;
    d_a      = 16'h0001;
    vcount   = 0;
    busy_99  = 1'b0;
    busy_100 = 1'b1;
    tick();
    drive(1'b1, 1'b1, 1'b1);
    for (int c = 1; c <= 150; c++) begin
      tick();
      drive(1'b0, 1'b0, (c == 80));
      if (bus_a.data_valid === 1'b1) begin
        vcount++;
        vcyc_q.push_back(c);
        word_q.push_back(bus_a.data_out);
        if (vcount == 1) d_a = 16'h8000;
      end
      if (c == 99)  busy_99  = bus_a.busy;
      if (c == 100) busy_100 = bus_a.busy;
    end
    chk("cont_valid_count", 32'(vcount), 32'(3));
    for (int k = 0; k < 3; k++) begin
      if (k < vcyc_q.size()) begin
        chk("cont_valid_cycle", 32'(vcyc_q[k]), 32'(33 * (k + 1)));
        chk("cont_word", 32'(word_q[k]), (k == 0) ? 32'h0001 : 32'h8000);
      end
    end
    chk("cont_busy_last_done", 32'(busy_99), 32'(1));
    chk("cont_idle_after_stop", 32'(busy_100), 32'(0));

    // Reset mid-sweep: abort, no valid, then a clean sweep
    fast = 1'b0;
    d_a  = 16'h5A5A;
    tick();
    drive(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      tick();
      drive(1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    tick();
    chk("midrst_sel",   32'(bus_a.sel),        32'(0));
    chk("midrst_dout",  32'(bus_a.data_out),   32'(0));
    chk("midrst_valid", 32'(bus_a.data_valid), 32'(0));
    chk("midrst_busy",  32'(bus_a.busy),       32'(0));
    rst    = 1'b0;
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus_a.data_valid === 1'b1) vcount++;
    end
    chk("midrst_no_valid", 32'(vcount), 32'(0));
    chk("midrst_stay_idle", 32'(bus_a.busy), 32'(0));
    w = 16'($urandom);
    single_sweep(1'b0, w, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
